// File: rtl/commit_trace_pkg.sv
// commit_trace_pkg
// Shared definitions for the commit trace buffer:
//   - trc_kind_e : record kind encodings (OTHER/REG/LOAD/STORE/HALT)
//   - trc_rec_t  : packed 71-bit trace record layout
//   - build_rec  : classifies one commit-stage beat into a record
package commit_trace_pkg;

  typedef enum logic [2:0] {
    KIND_OTHER = 3'd0,
    KIND_REG   = 3'd1,
    KIND_LOAD  = 3'd2,
    KIND_STORE = 3'd3,
    KIND_HALT  = 3'd4
  } trc_kind_e;

  // kind(3) + inum(16) + pc(16) + reg(4) + addr(16) + value(16) = 71 bits
  typedef struct packed {
    trc_kind_e   kind;
    logic [15:0] inum;
    logic [15:0] pc;
    logic [3:0]  rd;
    logic [15:0] addr;
    logic [15:0] value;
  } trc_rec_t;

  localparam int TRC_REC_W = $bits(trc_rec_t);

  // Classification priority: LOAD, REG, HALT, STORE, OTHER. Fields a kind
  // does not use stay zero so downstream tools can compare records directly.
  function automatic trc_rec_t build_rec(
    input logic        reg_write,
    input logic        mem_read,
    input logic        mem_write,
    input logic        hlt,
    input logic [3:0]  write_reg,
    input logic [15:0] write_data,
    input logic [15:0] mem_addr,
    input logic [15:0] mem_data,
    input logic [15:0] pc,
    input logic [15:0] inum
  );
    trc_rec_t rec;
    rec      = '0;
    rec.pc   = pc;
    rec.inum = inum;
    if (reg_write && mem_read) begin
      rec.kind  = KIND_LOAD;
      rec.rd    = write_reg;
      rec.value = write_data;
      rec.addr  = mem_addr;
    end else if (reg_write) begin
      rec.kind  = KIND_REG;
      rec.rd    = write_reg;
      rec.value = write_data;
    end else if (hlt) begin
      rec.kind  = KIND_HALT;
    end else if (mem_write) begin
      rec.kind  = KIND_STORE;
      rec.addr  = mem_addr;
      rec.value = mem_data;
    end else begin
      rec.kind  = KIND_OTHER;
    end
    return rec;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo
// Synchronous FIFO for trace records, supporting push and pop in the same
// cycle (a push into a full FIFO is accepted when a pop frees a slot).
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   push, wdata     : write request and data
//   pop             : read request (ignored when empty)
//   rdata           : head entry (valid when !empty)
//   full, empty     : occupancy flags
//   accept          : push actually written this cycle
module trace_fifo #(
  parameter int WIDTH = 71,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             accept
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_ok;

  assign full   = (count_q == DEPTH_C);
  assign empty  = (count_q == {CW{1'b0}});
  assign pop_ok = pop && !empty;
  assign accept = push && (!full || pop_ok);
  assign rdata  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy; pointers wrap naturally
  // because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({accept, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer
// Captures one trace record per cycle from the commit stage into a FIFO and
// presents the head on a valid/ready interface, with status counters.
// Optional feature: define COMMIT_TRACE_WDOG_EN to enable the watchdog that
// forces a HALT record and sets timeout when cycle_count reaches WDOG_LIMIT.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   pc, inst, reg_write, mem_read, mem_write, hlt, write_reg, write_data,
//   mem_addr, mem_data             : commit-stage inputs
//   trc_valid/trc_ready            : record handshake
//   trc_kind/inum/pc/reg/addr/value: head record fields (0 when empty)
//   inst_count, cycle_count, drop_count : status counters
//   halted, overflow, timeout      : sticky status
import commit_trace_pkg::*;

module commit_trace_buffer #(
  parameter int DEPTH      = 8,
  parameter int WDOG_LIMIT = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc,
  input  logic [15:0] inst,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        hlt,
  input  logic [3:0]  write_reg,
  input  logic [15:0] write_data,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  output logic        trc_valid,
  input  logic        trc_ready,
  output logic [2:0]  trc_kind,
  output logic [15:0] trc_inum,
  output logic [15:0] trc_pc,
  output logic [3:0]  trc_reg,
  output logic [15:0] trc_addr,
  output logic [15:0] trc_value,
  output logic [31:0] inst_count,
  output logic [31:0] cycle_count,
  output logic [15:0] drop_count,
  output logic        halted,
  output logic        overflow,
  output logic        timeout
);

  logic [31:0] inst_count_q, inst_count_d;
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [15:0] drop_count_q, drop_count_d;
  logic        halted_q, halted_d;
  logic        overflow_q, overflow_d;
  logic        timeout_q, timeout_d;

  logic        capturing_s;
  logic        wdog_hit_s;
  trc_rec_t    rec_s;
  trc_rec_t    head_s;
  logic [TRC_REC_W-1:0] fifo_rdata_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic        fifo_accept_s;
  logic        pop_s;
  logic        drop_s;

  // The instruction word is not part of the record layout.
  logic        unused_inst_s;
  assign unused_inst_s = ^inst;

  assign capturing_s = !halted_q && !timeout_q;

`ifdef COMMIT_TRACE_WDOG_EN
  // Fires in the cycle whose edge moves cycle_count onto WDOG_LIMIT.
  localparam logic [31:0] WDOG_LAST = 32'(WDOG_LIMIT - 1);
  assign wdog_hit_s = capturing_s && (cycle_count_q == WDOG_LAST);
`else
  assign wdog_hit_s = 1'b0;
`endif

  // Record for this cycle; a watchdog hit replaces it with a bare HALT.
  always_comb begin
    rec_s = build_rec(reg_write, mem_read, mem_write, hlt, write_reg,
                      write_data, mem_addr, mem_data, pc, inst_count_q[15:0]);
    if (wdog_hit_s) begin
      rec_s.kind  = KIND_HALT;
      rec_s.rd    = 4'd0;
      rec_s.addr  = 16'd0;
      rec_s.value = 16'd0;
    end else begin
      rec_s.kind  = rec_s.kind;
    end
  end

  assign pop_s  = !fifo_empty_s && trc_ready;
  assign drop_s = capturing_s && !fifo_accept_s;

  trace_fifo #(
    .WIDTH (TRC_REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (capturing_s),
    .pop    (pop_s),
    .wdata  (rec_s),
    .rdata  (fifo_rdata_s),
    .full   (fifo_full_s),
    .empty  (fifo_empty_s),
    .accept (fifo_accept_s)
  );

  // Counter and sticky-status next state.
  always_comb begin
    if (cycle_count_q != 32'hFFFF_FFFF) begin
      cycle_count_d = cycle_count_q + 32'd1;
    end else begin
      cycle_count_d = cycle_count_q;
    end
    // Dropped records still consume an instruction number.
    if (capturing_s) begin
      inst_count_d = inst_count_q + 32'd1;
    end else begin
      inst_count_d = inst_count_q;
    end
    if (drop_s && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end else begin
      drop_count_d = drop_count_q;
    end
    overflow_d = overflow_q | drop_s;
    halted_d   = halted_q | (capturing_s && (rec_s.kind == KIND_HALT));
    timeout_d  = timeout_q | wdog_hit_s;
  end

  // Status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_count_q  <= 32'd0;
      cycle_count_q <= 32'd0;
      drop_count_q  <= 16'd0;
      halted_q      <= 1'b0;
      overflow_q    <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      inst_count_q  <= inst_count_d;
      cycle_count_q <= cycle_count_d;
      drop_count_q  <= drop_count_d;
      halted_q      <= halted_d;
      overflow_q    <= overflow_d;
      timeout_q     <= timeout_d;
    end
  end

  // Head fields read as zero whenever nothing is queued.
  assign head_s    = fifo_empty_s ? trc_rec_t'('0) : trc_rec_t'(fifo_rdata_s);
  assign trc_valid = !fifo_empty_s;
  assign trc_kind  = head_s.kind;
  assign trc_inum  = head_s.inum;
  assign trc_pc    = head_s.pc;
  assign trc_reg   = head_s.rd;
  assign trc_addr  = head_s.addr;
  assign trc_value = head_s.value;

  assign inst_count  = inst_count_q;
  assign cycle_count = cycle_count_q;
  assign drop_count  = drop_count_q;
  assign halted      = halted_q;
  assign overflow    = overflow_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer
// Directed bench for commit_trace_buffer (DEPTH=8, WDOG_LIMIT=20).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Build with COMMIT_TRACE_WDOG_EN defined to run the watchdog scenario.
module tb_commit_trace_buffer;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc, inst, write_data, mem_addr, mem_data;
  logic        reg_write, mem_read, mem_write, hlt;
  logic [3:0]  write_reg;
  logic        trc_valid, trc_ready;
  logic [2:0]  trc_kind;
  logic [15:0] trc_inum, trc_pc, trc_addr, trc_value;
  logic [3:0]  trc_reg;
  logic [31:0] inst_count, cycle_count;
  logic [15:0] drop_count;
  logic        halted, overflow, timeout;

  int n_vec;
  int n_err;

  commit_trace_buffer #(.DEPTH(8), .WDOG_LIMIT(20)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .inst(inst),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .hlt(hlt),
    .write_reg(write_reg), .write_data(write_data), .mem_addr(mem_addr), .mem_data(mem_data),
    .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_kind(trc_kind), .trc_inum(trc_inum),
    .trc_pc(trc_pc), .trc_reg(trc_reg), .trc_addr(trc_addr), .trc_value(trc_value),
    .inst_count(inst_count), .cycle_count(cycle_count), .drop_count(drop_count),
    .halted(halted), .overflow(overflow), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    pc = 16'h0; inst = 16'h0; reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    hlt = 1'b0; write_reg = 4'h0; write_data = 16'h0; mem_addr = 16'h0; mem_data = 16'h0;
  endtask

  // Hold reset for two cycles, release on a falling edge.
  task automatic do_reset(input logic ready);
    clear_inputs();
    trc_ready = ready;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    trc_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (trc_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%0b exp=0", trc_valid); end
    n_vec++; if (inst_count !== 32'd0) begin n_err++; $display("FAIL rst_inst got=%0d exp=0", inst_count); end
    n_vec++; if (cycle_count !== 32'd0) begin n_err++; $display("FAIL rst_cycle got=%0d exp=0", cycle_count); end
    n_vec++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL rst_drop got=%0d exp=0", drop_count); end
    n_vec++; if ({halted, overflow, timeout} !== 3'b000) begin n_err++; $display("FAIL rst_sticky got=%b exp=000", {halted, overflow, timeout}); end
    n_vec++; if ({trc_kind, trc_inum, trc_pc, trc_reg, trc_addr, trc_value} !== 71'd0) begin n_err++; $display("FAIL rst_fields got nonzero exp=0"); end
    rst_n = 1'b1;
  endtask

  task automatic test_reg_load_store();
    do_reset(1'b1);
    reg_write = 1'b1; write_reg = 4'd3; write_data = 16'h00AB; pc = 16'h0002; inst = 16'h1234;
    step(1);
    n_vec++; if (trc_valid !== 1'b1) begin n_err++; $display("FAIL reg_valid got=%0b exp=1", trc_valid); end
    n_vec++; if (trc_kind !== 3'd1) begin n_err++; $display("FAIL reg_kind got=%0d exp=1", trc_kind); end
    n_vec++; if (trc_inum !== 16'd0) begin n_err++; $display("FAIL reg_inum got=%0d exp=0", trc_inum); end
    n_vec++; if (trc_reg !== 4'd3) begin n_err++; $display("FAIL reg_reg got=%0d exp=3", trc_reg); end
    n_vec++; if (trc_value !== 16'h00AB) begin n_err++; $display("FAIL reg_value got=%h exp=00ab", trc_value); end
    n_vec++; if (trc_pc !== 16'h0002) begin n_err++; $display("FAIL reg_pc got=%h exp=0002", trc_pc); end
    n_vec++; if (trc_addr !== 16'h0000) begin n_err++; $display("FAIL reg_addr got=%h exp=0000", trc_addr); end
    n_vec++; if (cycle_count !== 32'd1) begin n_err++; $display("FAIL reg_cycle got=%0d exp=1", cycle_count); end
    // load
    mem_read = 1'b1; mem_addr = 16'h0040; write_reg = 4'd5; write_data = 16'hBEEF; pc = 16'h0004;
    step(1);
    n_vec++; if (trc_kind !== 3'd2) begin n_err++; $display("FAIL load_kind got=%0d exp=2", trc_kind); end
    n_vec++; if (trc_addr !== 16'h0040) begin n_err++; $display("FAIL load_addr got=%h exp=0040", trc_addr); end
    n_vec++; if (trc_value !== 16'hBEEF) begin n_err++; $display("FAIL load_value got=%h exp=beef", trc_value); end
    n_vec++; if (trc_inum !== 16'd1) begin n_err++; $display("FAIL load_inum got=%0d exp=1", trc_inum); end
    // store: write_reg set but must not appear in record
    reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b1; mem_addr = 16'h0080; mem_data = 16'h1234;
    write_reg = 4'd7; pc = 16'h0006;
    step(1);
    n_vec++; if (trc_kind !== 3'd3) begin n_err++; $display("FAIL store_kind got=%0d exp=3", trc_kind); end
    n_vec++; if (trc_value !== 16'h1234) begin n_err++; $display("FAIL store_value got=%h exp=1234", trc_value); end
    n_vec++; if (trc_addr !== 16'h0080) begin n_err++; $display("FAIL store_addr got=%h exp=0080", trc_addr); end
    n_vec++; if (trc_reg !== 4'd0) begin n_err++; $display("FAIL store_reg got=%0d exp=0", trc_reg); end
    // other
    mem_write = 1'b0; pc = 16'h0008;
    step(1);
    n_vec++; if (trc_kind !== 3'd0) begin n_err++; $display("FAIL other_kind got=%0d exp=0", trc_kind); end
    n_vec++; if ({trc_reg, trc_addr, trc_value} !== 36'd0) begin n_err++; $display("FAIL other_fields got nonzero exp=0"); end
    n_vec++; if (inst_count !== 32'd4) begin n_err++; $display("FAIL other_icount got=%0d exp=4", inst_count); end
  endtask

  task automatic test_overflow();
    do_reset(1'b0);
    step(5);
    n_vec++; if (trc_inum !== 16'd0) begin n_err++; $display("FAIL ovf_hold_inum got=%0d exp=0", trc_inum); end
    step(5);
    n_vec++; if (drop_count !== 16'd2) begin n_err++; $display("FAIL ovf_drop got=%0d exp=2", drop_count); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
    n_vec++; if (inst_count !== 32'd10) begin n_err++; $display("FAIL ovf_icount got=%0d exp=10", inst_count); end
    trc_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (trc_inum !== 16'(i)) begin n_err++; $display("FAIL ovf_drain_%0d got=%0d exp=%0d", i, trc_inum, i); end
      step(1);
    end
    // records 8 and 9 were dropped; 10 was pushed while 0 popped
    n_vec++; if (trc_inum !== 16'd10) begin n_err++; $display("FAIL ovf_gap got=%0d exp=10", trc_inum); end
    n_vec++; if (drop_count !== 16'd2) begin n_err++; $display("FAIL ovf_drop_after got=%0d exp=2", drop_count); end
  endtask

  task automatic test_halt();
    do_reset(1'b0);
    hlt = 1'b1; reg_write = 1'b1; write_reg = 4'd2; write_data = 16'h0055; pc = 16'h0010;
    step(1);
    n_vec++; if (trc_kind !== 3'd1) begin n_err++; $display("FAIL halt_regfirst_kind got=%0d exp=1", trc_kind); end
    n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL halt_early got=%0b exp=0", halted); end
    reg_write = 1'b0; pc = 16'h0011;
    step(1);
    n_vec++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_set got=%0b exp=1", halted); end
    hlt = 1'b0; reg_write = 1'b1;
    step(2);
    n_vec++; if (inst_count !== 32'd2) begin n_err++; $display("FAIL halt_nocapture got=%0d exp=2", inst_count); end
    trc_ready = 1'b1;
    n_vec++; if ({trc_kind, trc_inum, trc_reg, trc_value} !== {3'd1, 16'd0, 4'd2, 16'h0055}) begin n_err++; $display("FAIL halt_drain0 got=%0d/%0d/%0d/%h exp=1/0/2/0055", trc_kind, trc_inum, trc_reg, trc_value); end
    step(1);
    n_vec++; if ({trc_kind, trc_inum, trc_pc, trc_reg} !== {3'd4, 16'd1, 16'h0011, 4'd0}) begin n_err++; $display("FAIL halt_drain1 got=%0d/%0d/%h/%0d exp=4/1/0011/0", trc_kind, trc_inum, trc_pc, trc_reg); end
    step(1);
    n_vec++; if (trc_valid !== 1'b0) begin n_err++; $display("FAIL halt_empty got=%0b exp=0", trc_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    reg_write = 1'b1; write_reg = 4'd1; write_data = 16'h0011;
    step(5);
    n_vec++; if (inst_count !== 32'd5) begin n_err++; $display("FAIL mid_queued got=%0d exp=5", inst_count); end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (trc_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid got=%0b exp=0", trc_valid); end
    n_vec++; if ({inst_count, cycle_count, drop_count} !== 80'd0) begin n_err++; $display("FAIL mid_counters got=%0d/%0d/%0d exp=0/0/0", inst_count, cycle_count, drop_count); end
    @(negedge clk);
    rst_n = 1'b1; trc_ready = 1'b1; write_data = 16'h0077;
    step(1);
    n_vec++; if ({trc_kind, trc_inum, trc_value} !== {3'd1, 16'd0, 16'h0077}) begin n_err++; $display("FAIL mid_first got=%0d/%0d/%h exp=1/0/0077", trc_kind, trc_inum, trc_value); end
  endtask

  task automatic test_no_wdog();
    do_reset(1'b1);
    step(25);
    n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL nowdog_timeout got=%0b exp=0", timeout); end
    n_vec++; if (cycle_count !== 32'd25) begin n_err++; $display("FAIL nowdog_cycle got=%0d exp=25", cycle_count); end
    n_vec++; if ({trc_valid, trc_inum} !== {1'b1, 16'd24}) begin n_err++; $display("FAIL nowdog_capture got=%0b/%0d exp=1/24", trc_valid, trc_inum); end
  endtask

  task automatic test_watchdog();
    do_reset(1'b1);
    step(19);
    n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL wdog_early got=%0b exp=0", timeout); end
    n_vec++; if (cycle_count !== 32'd19) begin n_err++; $display("FAIL wdog_cycle19 got=%0d exp=19", cycle_count); end
    reg_write = 1'b1; write_reg = 4'd9; write_data = 16'h0099; pc = 16'h0020;
    step(1);
    n_vec++; if (timeout !== 1'b1) begin n_err++; $display("FAIL wdog_timeout got=%0b exp=1", timeout); end
    n_vec++; if (cycle_count !== 32'd20) begin n_err++; $display("FAIL wdog_cycle20 got=%0d exp=20", cycle_count); end
    n_vec++; if ({trc_kind, trc_inum, trc_pc, trc_reg, trc_value} !== {3'd4, 16'd19, 16'h0020, 4'd0, 16'd0}) begin n_err++; $display("FAIL wdog_record got=%0d/%0d/%h/%0d/%h exp=4/19/0020/0/0000", trc_kind, trc_inum, trc_pc, trc_reg, trc_value); end
    step(1);
    n_vec++; if ({trc_valid, inst_count} !== {1'b0, 32'd20}) begin n_err++; $display("FAIL wdog_stop got=%0b/%0d exp=0/20", trc_valid, inst_count); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    trc_ready = 1'b0;
    clear_inputs();
    test_reset();
`ifdef COMMIT_TRACE_WDOG_EN
    test_watchdog();
`else
    test_reg_load_store();
    test_overflow();
    test_halt();
    test_reset_mid();
    test_no_wdog();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/commit_trace_buffer.md
COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter WDOG_LIMIT, default 100000, cycle limit before timeout.
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous active-low.
REQ-005 SHALL have ports pc, inst, input, 16 each, commit-stage PC and instruction.
REQ-006 SHALL have ports reg_write, mem_read, mem_write, hlt, input, 1 each, commit-stage controls.
REQ-007 SHALL have ports write_reg (4), write_data (16), mem_addr (16), mem_data (16), inputs, commit-stage data.
REQ-008 SHALL have ports trc_valid output 1, trc_ready input 1, trace record handshake.
REQ-009 SHALL have outputs trc_kind 3, trc_inum 16, trc_pc 16, trc_reg 4, trc_addr 16, trc_value 16, head record fields.
REQ-010 SHALL have outputs inst_count 32, cycle_count 32, drop_count 16, status counters.
REQ-011 SHALL have outputs halted, overflow, timeout, 1 each, sticky status.

Function
REQ-012 SHALL increment cycle_count on every rising edge while rst_n high, saturating at 2^32-1.
REQ-013 SHALL capture exactly one record per cycle while capturing (capturing = not halted and not timeout).
REQ-014 SHALL classify with priority: reg_write&mem_read -> LOAD(2); reg_write -> REG(1); hlt -> HALT(4); mem_write -> STORE(3); else OTHER(0).
REQ-015 SHALL fill fields: REG/LOAD trc_reg=write_reg, trc_value=write_data; LOAD/STORE trc_addr=mem_addr; STORE trc_value=mem_data; unused fields 0.
REQ-016 SHALL stamp trc_inum with inst_count[15:0] before the increment, then increment inst_count by 1 per captured record (wraps at 2^32).
REQ-017 SHALL, on capturing a HALT record, set halted the following cycle and capture nothing further.
REQ-018 SHALL set timeout when cycle_count reaches WDOG_LIMIT while not halted, and then capture a HALT record in that cycle instead of the classified one.
REQ-019 SHALL present the FIFO head on trc_* with trc_valid=1 when non-empty; record leaves on trc_valid&trc_ready.
REQ-020 SHALL accept a push when full only if a pop occurs the same cycle; otherwise drop the record, increment drop_count (saturating at 16'hFFFF) and set overflow.
REQ-021 SHALL still increment inst_count for dropped records (inum gaps reveal drops).
REQ-022 SHALL hold trc_* stable while trc_valid=1 and trc_ready=0.
REQ-023 SHALL have write-to-read latency of one cycle (record captured at edge N visible on trc_* after edge N).
REQ-024 SHALL continue draining the FIFO after halted/timeout.

Reset
REQ-025 SHALL, on rst_n low, asynchronously clear FIFO pointers, all counters, halted, overflow, timeout; trc_valid=0; trc_* fields 0.
REQ-026 SHALL discard any queued records on reset mid-operation; first post-reset record has trc_inum=0.

Configuration
REQ-027 SHALL implement the watchdog (REQ-018) only when macro COMMIT_TRACE_WDOG_EN is defined; without it timeout is tied 0 and capture stops only on halt.

Structure
REQ-028 SHALL place record-kind encodings (OTHER/REG/LOAD/STORE/HALT) and the packed 71-bit record layout in shared package commit_trace_pkg.
REQ-029 SHALL implement storage as one sub-module trace_fifo (parameterised width/depth, full/empty, simultaneous push/pop).

Verification
REQ-030 SHALL test: reg_write=1, write_reg=3, write_data=16'h00AB, pc=16'h0002 -> record kind 1, inum 0, reg 3, value 16'h00AB.
REQ-031 SHALL test: reg_write=1, mem_read=1, mem_addr=16'h0040 -> kind 2, addr 16'h0040; mem_write=1 only, mem_data=16'h1234 -> kind 3, value 16'h1234.
REQ-032 SHALL test: trc_ready=0 for 10 capturing cycles, DEPTH=8 -> 8 queued, drop_count=2, overflow=1, next drained inum sequence 0..7.
REQ-033 SHALL test: hlt=1 and reg_write=1 same cycle -> REG record; hlt=1 alone next cycle -> HALT record, halted=1, no further records.
REQ-034 SHALL test: COMMIT_TRACE_WDOG_EN defined, WDOG_LIMIT=20, no halt -> timeout=1 at cycle 20, final record kind 4.
REQ-035 SHALL test: rst_n pulsed low with 5 records queued -> trc_valid=0 immediately, counters 0, next record inum 0.
